// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one external combinational adder among NUM_REQ requesters
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 4,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         adder_a,
  output logic [WIDTH-1:0]         adder_b,
  input  logic [WIDTH-1:0]         adder_sum,
  input  logic                     adder_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e state_q, state_d;
  logic [IDW-1:0] last_grant_q, grant, id_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic carry_q, valid_q, any_valid, accept;
  assign any_valid = |req_valid;
  assign accept = (state_q == IDLE) && any_valid;
  // Scan downward so the lowest offset above last_grant wins; offset NUM_REQ is last_grant itself.
  always_comb begin
    int idx;
    grant = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (req_valid[idx]) grant = IDW'(idx);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE) ? (any_valid ? EXEC : IDLE) :
              (state_q == EXEC) ? RESP :
              (state_q == RESP && !rsp_ready) ? RESP : IDLE;
  always_comb begin
    req_ready = accept ? (NUM_REQ'(1) << grant) : '0;
    busy = (state_q != IDLE);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      last_grant_q <= IDW'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        a_q <= req_a[int'(grant)*WIDTH +: WIDTH];
        b_q <= req_b[int'(grant)*WIDTH +: WIDTH];
        id_q <= grant;
      end
      if (state_q == EXEC) begin
        sum_q <= adder_sum;
        carry_q <= adder_carry;
        valid_q <= 1'b1;
      end
      if (state_q == RESP && rsp_ready) begin
        valid_q <= 1'b0;
        last_grant_q <= id_q;
      end
    end
  assign adder_a = a_q;
  assign adder_b = b_q;
  assign rsp_valid = valid_q;
  assign rsp_sum = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_id = id_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: table vectors plus corner sequences, responses checked against a scoreboard queue
module tb_adder_share_arbiter;
  logic clk = 1'b0, reset = 1'b1, rsp_ready = 1'b1;
  logic [3:0] req_valid = '0, req_ready;
  logic [15:0] req_a = '0, req_b = '0;
  logic [3:0] adder_a, adder_b, adder_sum, rsp_sum;
  logic adder_carry, rsp_valid, rsp_carry, busy;
  logic [1:0] rsp_id;
  int n_vec = 0, n_bad = 0, cyc = 0;
  typedef struct {logic [1:0] id; logic [3:0] sum; logic carry;} exp_t;
  typedef struct {int id; logic [3:0] a; logic [3:0] b; logic [3:0] s; logic c;} vec_t;
  exp_t q[$];
  vec_t tbl[6];
  adder_share_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .adder_a(adder_a), .adder_b(adder_b),
    .adder_sum(adder_sum), .adder_carry(adder_carry), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .rsp_id(rsp_id), .busy(busy)
  );
  assign {adder_carry, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (!reset && rsp_valid && rsp_ready) begin
      if (q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        check("rsp_carry", 32'(rsp_carry), 32'(e.carry));
      end
    end
  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        g = req_ready;
        break;
      end
    end
  endtask
  task automatic push(input int id, input logic [3:0] s, input logic c);
    exp_t e;
    e.id = 2'(id);
    e.sum = s;
    e.carry = c;
    q.push_back(e);
  endtask
  // Returns one tick after the accepting edge, i.e. while the DUT is in EXEC.
  task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b,
                       input bit do_push, input logic [3:0] s, input logic c);
    logic [3:0] g;
    @(posedge clk); #1;
    req_a[id*4 +: 4] = a;
    req_b[id*4 +: 4] = b;
    req_valid = 4'(1 << id);
    wait_grant(g);
    check("grant", 32'(g), 32'(1 << id));
    if (do_push) push(id, s, c);
    @(posedge clk); #1;
    req_valid = '0;
  endtask
  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    check("drain", 32'(ok), 1);
  endtask
  initial begin
    logic [3:0] g;
    logic [4:0] r;
    bit seen;
    int prev;
    tbl[0] = '{0, 4'd3, 4'd5, 4'd8, 1'b0};
    tbl[1] = '{2, 4'd15, 4'd15, 4'd14, 1'b1};
    tbl[2] = '{1, 4'd7, 4'd9, 4'd0, 1'b1};
    tbl[3] = '{3, 4'd0, 4'd0, 4'd0, 1'b0};
    tbl[4] = '{1, 4'd8, 4'd7, 4'd15, 1'b0};
    tbl[5] = '{0, 4'd12, 4'd5, 4'd1, 1'b1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_vals", {rsp_valid, rsp_carry, rsp_sum, rsp_id, busy, adder_a, adder_b, req_ready}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    // reset in the middle of EXEC discards the op
    issue(2, 4'd6, 4'd7, 0, 4'd0, 1'b0);
    check("exec_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("async_reset", {rsp_valid, busy, adder_a, adder_b}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    check("no_rsp_after_reset", 32'(seen), 0);
    // fairness: all valid, order 0,1,2,3,0 every 3 cycles
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      req_a[i*4 +: 4] = 4'(i + 1);
      req_b[i*4 +: 4] = 4'(2*i + 3);
    end
    req_valid = 4'hf;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      check("fair_grant", 32'(g), 32'(1 << (k % 4)));
      if (k > 0) check("fair_spacing", 32'(cyc - prev), 3);
      prev = cyc;
      r = {1'b0, 4'(k % 4 + 1)} + {1'b0, 4'(2*(k % 4) + 3)};
      push(k % 4, r[3:0], r[4]);
    end
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    // table vectors with latency and operand-hold checks
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].id, tbl[i].a, tbl[i].b, 1, tbl[i].s, tbl[i].c);
      check("exec_operands", {busy, rsp_valid, adder_a, adder_b}, {1'b1, 1'b0, tbl[i].a, tbl[i].b});
      @(negedge clk);
      check("lat_exec", 32'(rsp_valid), 0);
      @(negedge clk);
      check("lat_resp", 32'(rsp_valid), 1);
      drain();
    end
    // backpressure: 5 stalled cycles in RESP while another requester waits
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(0, 4'd9, 4'd4, 1, 4'd13, 1'b0);
    req_a[7:4] = 4'd2;
    req_valid = 4'b0010;
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid, rsp_id, rsp_carry, rsp_sum, req_ready}, {1'b1, 2'd0, 1'b0, 4'd13, 4'd0});
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_complete", {rsp_valid, busy}, 0);
    drain();
    // skip: last_grant=1, only req1 and req3 valid -> 3 then 1
    issue(1, 4'd1, 4'd1, 1, 4'd2, 1'b0);
    drain();
    @(posedge clk); #1;
    req_a[7:4] = 4'd10; req_b[7:4] = 4'd10;
    req_a[15:12] = 4'd4; req_b[15:12] = 4'd11;
    req_valid = 4'b1010;
    wait_grant(g);
    check("skip_grant3", 32'(g), 32'b1000);
    push(3, 4'd15, 1'b0);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    wait_grant(g);
    check("skip_grant1", 32'(g), 32'b0010);
    push(1, 4'd4, 1'b1);
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
